// File: rtl/hsv_wheel_pwm.sv
// hsv_wheel_pwm: six-segment hue-wheel sequencer feeding a three-channel PWM whose duties are shadowed at period wrap.
// Define HSV_WHEEL_BRIGHTNESS_EN to add a global 8-bit brightness scale applied at shadow load.
module hsv_wheel_pwm #(
  parameter int  PWM_INTERVAL      = 1200,
  parameter int  STEPS_PER_SEGMENT = 200,
  parameter int  STEP_INTERVAL     = 10000,
  localparam int W                 = $clog2(PWM_INTERVAL + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         dir,
`ifdef HSV_WHEEL_BRIGHTNESS_EN
  input  logic [7:0]   brightness,
`endif
  output logic [W-1:0] duty_r,
  output logic [W-1:0] duty_g,
  output logic [W-1:0] duty_b,
  output logic [2:0]   segment,
  output logic         wrap,
  output logic         pwm_r,
  output logic         pwm_g,
  output logic         pwm_b
);

  localparam int INC = PWM_INTERVAL / STEPS_PER_SEGMENT;
  localparam int TW  = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam int SW  = (STEPS_PER_SEGMENT > 1) ? $clog2(STEPS_PER_SEGMENT) : 1;
  localparam int CW  = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;

  localparam logic [W-1:0]  DUTY_MAX   = W'(PWM_INTERVAL);
  localparam logic [W-1:0]  DUTY_INC   = W'(INC);
  localparam logic [W-1:0]  RISE_TOP   = W'(PWM_INTERVAL - INC);
  localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_INTERVAL - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEPS_PER_SEGMENT - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(PWM_INTERVAL - 1);

  generate
    if (PWM_INTERVAL % STEPS_PER_SEGMENT != 0) begin : g_bad_steps
      $error("hsv_wheel_pwm: PWM_INTERVAL must be a multiple of STEPS_PER_SEGMENT");
    end
  endgenerate

  logic [TW-1:0]       timer_q, timer_d;
  logic                tick;
  logic [SW-1:0]       step_q, step_d;
  logic [2:0]          seg_q, seg_d;
  logic [W-1:0]        rise_q, rise_d;
  logic [W-1:0]        fall;
  logic                wrap_q, wrap_d;
  logic [2:0][W-1:0]   duty_q, duty_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                cnt_wrap;
  logic [2:0]          pwm_bus;

  always_comb begin
    tick    = en && (timer_q == TIMER_LAST);
    timer_d = timer_q;
    if (en) begin
      timer_d = tick ? '0 : timer_q + TW'(1);
    end
  end

  // rise tracks step*INC incrementally; fall is its complement against full scale
  always_comb begin
    step_d = step_q;
    seg_d  = seg_q;
    rise_d = rise_q;
    wrap_d = 1'b0;
    if (tick) begin
      if (!dir) begin
        if (step_q == STEP_LAST) begin
          step_d = '0;
          rise_d = '0;
          if (seg_q == 3'd5) begin
            seg_d  = 3'd0;
            wrap_d = 1'b1;
          end else begin
            seg_d = seg_q + 3'd1;
          end
        end else begin
          step_d = step_q + SW'(1);
          rise_d = rise_q + DUTY_INC;
        end
      end else begin
        if (step_q == '0) begin
          step_d = STEP_LAST;
          rise_d = RISE_TOP;
          if (seg_q == 3'd0) begin
            seg_d  = 3'd5;
            wrap_d = 1'b1;
          end else begin
            seg_d = seg_q - 3'd1;
          end
        end else begin
          step_d = step_q - SW'(1);
          rise_d = rise_q - DUTY_INC;
        end
      end
    end
  end

  always_comb begin
    fall   = DUTY_MAX - rise_d;
    duty_d = duty_q;
    if (tick) begin
      case (seg_d)
        3'd0:    begin duty_d[0] = DUTY_MAX; duty_d[1] = rise_d;   duty_d[2] = '0;       end
        3'd1:    begin duty_d[0] = fall;     duty_d[1] = DUTY_MAX; duty_d[2] = '0;       end
        3'd2:    begin duty_d[0] = '0;       duty_d[1] = DUTY_MAX; duty_d[2] = rise_d;   end
        3'd3:    begin duty_d[0] = '0;       duty_d[1] = fall;     duty_d[2] = DUTY_MAX; end
        3'd4:    begin duty_d[0] = rise_d;   duty_d[1] = '0;       duty_d[2] = DUTY_MAX; end
        default: begin duty_d[0] = DUTY_MAX; duty_d[1] = '0;       duty_d[2] = fall;     end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q   <= '0;
      step_q    <= '0;
      seg_q     <= 3'd0;
      rise_q    <= '0;
      wrap_q    <= 1'b0;
      duty_q[0] <= DUTY_MAX;
      duty_q[1] <= '0;
      duty_q[2] <= '0;
    end else begin
      timer_q <= timer_d;
      step_q  <= step_d;
      seg_q   <= seg_d;
      rise_q  <= rise_d;
      wrap_q  <= wrap_d;
      duty_q  <= duty_d;
    end
  end

  // PWM period counter free-runs regardless of en so the shadow cadence never drifts
  always_comb begin
    cnt_wrap = (cnt_q == CNT_LAST);
    cnt_d    = cnt_wrap ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      localparam logic [W-1:0] RST_DUTY = (gi == 0) ? DUTY_MAX : '0;
      logic [W-1:0] shadow_q, shadow_d;
      logic         pwm_q, pwm_d;
`ifdef HSV_WHEEL_BRIGHTNESS_EN
      logic [W+8:0] scaled;
      always_comb begin
        scaled   = {9'd0, duty_q[gi]} * {{W{1'b0}}, ({1'b0, brightness} + 9'd1)};
        shadow_d = W'(scaled >> 8);
      end
`else
      always_comb shadow_d = duty_q[gi];
`endif
      always_comb pwm_d = en && (W'(cnt_q) < shadow_q);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_q <= RST_DUTY;
          pwm_q    <= 1'b0;
        end else begin
          if (cnt_wrap) begin
            shadow_q <= shadow_d;
          end
          pwm_q <= pwm_d;
        end
      end

      assign pwm_bus[gi] = pwm_q;
    end
  endgenerate

  assign duty_r  = duty_q[0];
  assign duty_g  = duty_q[1];
  assign duty_b  = duty_q[2];
  assign segment = seg_q;
  assign wrap    = wrap_q;
  assign pwm_r   = pwm_bus[0];
  assign pwm_g   = pwm_bus[1];
  assign pwm_b   = pwm_bus[2];

endmodule

// File: tb/tb_hsv_wheel_pwm.sv
// Self-checking bench for hsv_wheel_pwm: directed scenarios plus a randomized run against a hue-index reference model.
module tb_hsv_wheel_pwm;
  localparam int P   = 12;
  localparam int S   = 4;
  localparam int T   = 5;
  localparam int INC = P / S;
  localparam int NH  = 6 * S;
  localparam int W   = $clog2(P + 1);

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         en    = 1'b0;
  logic         dir   = 1'b0;
`ifdef HSV_WHEEL_BRIGHTNESS_EN
  logic [7:0]   brightness = 8'd255;
`endif
  logic [W-1:0] duty_r, duty_g, duty_b;
  logic [2:0]   segment;
  logic         wrap, pwm_r, pwm_g, pwm_b;

  int total  = 0;
  int passed = 0;

  // Reference model: hue index h = segment*S + step, plus PWM counter/shadow per channel.
  int m_timer, m_h, m_wrap, m_cnt;
  int m_sh[3];
  int m_pwm[3];

  always #5 clk = ~clk;

  hsv_wheel_pwm #(.PWM_INTERVAL(P), .STEPS_PER_SEGMENT(S), .STEP_INTERVAL(T)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .dir(dir),
`ifdef HSV_WHEEL_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .duty_r(duty_r),
    .duty_g(duty_g),
    .duty_b(duty_b),
    .segment(segment),
    .wrap(wrap),
    .pwm_r(pwm_r),
    .pwm_g(pwm_g),
    .pwm_b(pwm_b)
  );

  function automatic int duty_of(input int h, input int c);
    int s    = h / S;
    int rise = (h % S) * INC;
    int fall = P - rise;
    int v[3];
    case (s)
      0:       v = '{P, rise, 0};
      1:       v = '{fall, P, 0};
      2:       v = '{0, P, rise};
      3:       v = '{0, fall, P};
      4:       v = '{rise, 0, P};
      default: v = '{P, 0, fall};
    endcase
    return v[c];
  endfunction

  function automatic int scale(input int x);
`ifdef HSV_WHEEL_BRIGHTNESS_EN
    return (x * (int'(brightness) + 1)) / 256;
`else
    return x;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_timer = 0;
    m_h     = 0;
    m_wrap  = 0;
    m_cnt   = 0;
    m_sh    = '{P, 0, 0};
    m_pwm   = '{0, 0, 0};
  endtask

  task automatic model_edge();
    for (int c = 0; c < 3; c++) m_pwm[c] = (en && (m_cnt < m_sh[c])) ? 1 : 0;
    if (m_cnt == P - 1) begin
      for (int c = 0; c < 3; c++) m_sh[c] = scale(duty_of(m_h, c));
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
    m_wrap = 0;
    if (en) begin
      if (m_timer == T - 1) begin
        m_timer = 0;
        if (!dir) begin
          if (m_h == NH - 1) m_wrap = 1;
          m_h = (m_h + 1) % NH;
        end else begin
          if (m_h == 0) m_wrap = 1;
          m_h = (m_h + NH - 1) % NH;
        end
      end else begin
        m_timer++;
      end
    end
  endtask

  task automatic compare_all();
    check("duty_r", duty_r, duty_of(m_h, 0));
    check("duty_g", duty_g, duty_of(m_h, 1));
    check("duty_b", duty_b, duty_of(m_h, 2));
    check("segment", segment, m_h / S);
    check("wrap", wrap, m_wrap);
    check("pwm_r", pwm_r, m_pwm[0]);
    check("pwm_g", pwm_g, m_pwm[1]);
    check("pwm_b", pwm_b, m_pwm[2]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_duty_r"}, duty_r, P);
    check({tag, "_duty_g"}, duty_g, 0);
    check({tag, "_duty_b"}, duty_b, 0);
    check({tag, "_segment"}, segment, 0);
    check({tag, "_wrap"}, wrap, 0);
    check({tag, "_pwm"}, {pwm_r, pwm_g, pwm_b}, 0);
  endtask

  // Asserts reset off-edge, checks asynchronously, optionally holds across clock edges, releases off-edge.
  task automatic apply_reset(input int edges);
    rst_n = 1'b0;
    #2;
    reset_checks("rst_async");
    if (edges > 0) begin
      repeat (edges) @(posedge clk);
      #1;
      reset_checks("rst_hold");
      #2;
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int hi;
    en  = 1'b1;
    dir = 1'b0;
    #1;

    apply_reset(2);
    hi = 0;
    for (int i = 1; i <= 121; i++) begin
      cycle();
      if (i <= 24) check("pwm_r_full_scale", pwm_r, 1);
      if (i <= 40) check("pwm_b_zero_duty", pwm_b, 0);
      if (i >= 13 && i <= 24) hi += int'(pwm_g);
      if (i == 5) check("first_tick_duty_g", duty_g, 3);
      if (i == 20) begin
        check("tick4_segment", segment, 1);
        check("tick4_duty", {duty_r, duty_g, duty_b}, {4'd12, 4'd12, 4'd0});
      end
      if (i == 40) check("tick8_duty", {duty_r, duty_g, duty_b}, {4'd0, 4'd12, 4'd0});
      if (i == 120) begin
        check("tick24_segment", segment, 0);
        check("tick24_duty", {duty_r, duty_g, duty_b}, {4'd12, 4'd0, 4'd0});
        check("tick24_wrap", wrap, 1);
      end
      if (i == 121) check("wrap_one_cycle", wrap, 0);
    end
    check("shadow_window_g", hi, 6);

    dir = 1'b1;
    apply_reset(0);
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (i == 5) begin
        check("rev_segment", segment, 5);
        check("rev_duty", {duty_r, duty_g, duty_b}, {4'd12, 4'd0, 4'd3});
        check("rev_wrap", wrap, 1);
      end
      if (i == 6) check("rev_wrap_clear", wrap, 0);
      if (i == 10) check("rev_duty2", {duty_r, duty_g, duty_b}, {4'd12, 4'd0, 4'd6});
    end

    dir = 1'b0;
    apply_reset(0);
    repeat (7) cycle();
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("en_off_pwm", {pwm_r, pwm_g, pwm_b}, 0);
      check("en_off_duty_g", duty_g, 3);
    end
    en = 1'b1;
    cycle();
    cycle();
    check("resume_before_tick", duty_g, 3);
    cycle();
    check("resume_tick", duty_g, 6);
    repeat (4) cycle();
    apply_reset(0);

`ifdef HSV_WHEEL_BRIGHTNESS_EN
    brightness = 8'd127;
    apply_reset(0);
    hi = 0;
    for (int i = 1; i <= 36; i++) begin
      cycle();
      if (i == 12) brightness = 8'd0;
      if (i >= 13 && i <= 24) hi += int'(pwm_r);
      if (i == 24) begin
        check("bright127_window_r", hi, 6);
        hi = 0;
      end
    end
    check("bright0_window_r", hi, 0);
    brightness = 8'd255;
`endif

    apply_reset(0);
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) dir = $urandom_range(0, 1) != 0;
`ifdef HSV_WHEEL_BRIGHTNESS_EN
      if ($urandom_range(0, 7) == 0) brightness = 8'($urandom_range(0, 255));
`endif
      if ($urandom_range(0, 199) == 0) apply_reset(0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hsv_wheel_pwm.md
Name: hsv_wheel_pwm

Overview:
- Parametrised successor to the single-speed RGB colour-wheel fader.
- Sweeps hue smoothly through six segments (R→Y→G→C→B→M→R) in configurable step resolution, forward or reverse.
- Contains the three-channel PWM generator, with glitch-free duty shadowing.
- Sits between top-level control (enable/direction) and the RGB LED pins; also exports duty values and segment for debug.

Parameters:
- PWM_INTERVAL, 1200: PWM period in clk cycles; also full-scale duty.
- STEPS_PER_SEGMENT, 200: ramp steps per hue segment. PWM_INTERVAL % STEPS_PER_SEGMENT must be 0; violation is an elaboration-time error.
- STEP_INTERVAL, 10000: enabled clk cycles per step. Default full wheel = 6*200*10000 = 12M cycles = 1 s at 12 MHz.
- Derived localparams:
  - W = $clog2(PWM_INTERVAL+1)
  - INC = PWM_INTERVAL/STEPS_PER_SEGMENT

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; low freezes hue and forces PWM outputs low
- dir  in  1  0 = forward (R→Y→G…), 1 = reverse
- duty_r / duty_g / duty_b  out  W  current target duty per channel
- segment  out  3  current hue segment 0..5
- wrap  out  1  one-cycle pulse on full-wheel wrap
- pwm_r / pwm_g / pwm_b  out  1  registered PWM outputs

Behaviour:
- Reset (async assert, sync release):
  - step timer = 0, step = 0, segment = 0.
  - duty_r = PWM_INTERVAL, duty_g = 0, duty_b = 0.
  - Shadow duties equal the reset duties.
  - PWM counter = 0, pwm_* = 0, wrap = 0.
- Step timer:
  - Counts 0..STEP_INTERVAL-1 while en = 1; holds while en = 0.
  - tick = en && (timer == STEP_INTERVAL-1); the timer wraps to 0 on the same edge.
- Phase advance on tick:
  - Forward: step+1. At step STEPS_PER_SEGMENT-1, go to step 0 and segment+1; segment 5→0 pulses wrap.
  - Reverse: step-1. At step 0, go to step STEPS_PER_SEGMENT-1 and segment-1; segment 0→5 pulses wrap.
  - dir is sampled only at tick; a change mid-step never glitches the outputs.
- Duty mapping (rise = step*INC, fall = PWM_INTERVAL - step*INC, kept incrementally, no multiplier). Per segment (R, G, B):
  - seg 0: (MAX, rise, 0)
  - seg 1: (fall, MAX, 0)
  - seg 2: (0, MAX, rise)
  - seg 3: (0, fall, MAX)
  - seg 4: (rise, 0, MAX)
  - seg 5: (MAX, 0, fall)
- Duty registers update on the tick edge. Values never exceed PWM_INTERVAL and never underflow.
- PWM:
  - Counter runs 0..PWM_INTERVAL-1 continuously, including when en = 0.
  - Shadow duties load from duty_* only when the counter wraps to 0.
  - pwm_x <= en && (pwm_cnt < shadow_x), registered.
  - Duty 0 → constant low; duty PWM_INTERVAL → constant high.
- en deasserted mid-operation: pwm_* low from the next edge; hue, step and timer frozen. Reassertion resumes exactly where it stopped.
- Reset mid-operation returns to the reset state immediately, regardless of clock.

Optional Feature:
- Macro: HSV_WHEEL_BRIGHTNESS_EN.
- Defined:
  - Adds input brightness [7:0].
  - Shadow load value = (duty_x*(brightness+1))>>8, computed on the shadow-load edge. brightness = 255 gives unscaled duty.
  - duty_* outputs remain unscaled.
- Undefined: no brightness port; shadow = duty_x directly.

Test Plan (PWM_INTERVAL=12, STEPS_PER_SEGMENT=4, STEP_INTERVAL=5, so INC=3):
1. Assert rst_n = 0, then release with en = 1 → duty = (12,0,0), segment = 0, pwm_* = 0 during reset; after 5 enabled cycles duty_g = 3.
2. Forward run, 24 ticks (120 cycles) → after tick 4: segment = 1, duty = (12,12,0); after tick 8: (0,12,0); at tick 24: segment = 0, duty = (12,0,0), wrap high exactly 1 cycle.
3. From reset, dir = 1, 1 tick → segment = 5, step = 3, duty = (12,0,3), wrap pulse; next tick → (12,0,6).
4. duty_g = 3 held → pwm_g high 3 of every 12 cycles. A duty change mid-period takes effect only at the next counter wrap; duty = 12 gives constant high.
5. en = 0 at timer = 2 for 20 cycles → pwm_* low, duty/segment unchanged; after reassertion the next tick comes 3 enabled cycles later. Then rst_n pulse mid-segment → immediate return to (12,0,0).
6. (HSV_WHEEL_BRIGHTNESS_EN) brightness = 127, duty_r = 12 → shadow 6, pwm_r high 6 of 12 cycles; brightness = 0 → shadow 0.
